// File: rtl/motor_step_engine.sv
// Step/direction pulse generator for one stepper axis with a one-deep segment holding buffer.
// Optional signed position counter enabled by defining POSITION_TRACK_EN.
module motor_step_engine #(
  parameter int unsigned DIV_W  = 15,
  parameter int unsigned STEP_W = 14,
  parameter int unsigned POS_W  = 19
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DIV_W-1:0]  cmd_divider,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              abort,
  output logic              dir,
  output logic              step,
  output logic              busy,
  output logic              done
`ifdef POSITION_TRACK_EN
  ,
  output logic [POS_W-1:0]  position
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              full_q, full_d;
  logic [DIV_W-1:0]  buf_div_q, buf_div_d;
  logic [STEP_W-1:0] buf_steps_q, buf_steps_d;
  logic              buf_dir_q, buf_dir_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              done_q, done_d;
  logic              rise_c;
  logic              accept_c;
  logic [DIV_W-1:0]  half_c;

  assign half_c    = div_q >> 1;
  assign accept_c  = cmd_valid && !full_q && !abort;
  assign cmd_ready = !full_q;
  assign busy      = (state_q != S_IDLE) || full_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign done      = done_q;

  // Next-state logic: abort overrides both the engine and the handshake.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    buf_div_d   = buf_div_q;
    buf_steps_d = buf_steps_q;
    buf_dir_d   = buf_dir_q;
    div_d       = div_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    step_d      = step_q;
    done_d      = 1'b0;
    rise_c      = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      step_d  = 1'b0;
      full_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (full_q) begin
            div_d  = (buf_div_q < DIV_W'(2)) ? DIV_W'(2) : buf_div_q;
            rem_d  = buf_steps_q;
            dir_d  = buf_dir_q;
            full_d = 1'b0;
            if (buf_steps_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_SETUP;
            end
          end
        end
        S_SETUP: begin
          step_d  = 1'b1;
          cnt_d   = half_c - DIV_W'(1);
          state_d = S_HIGH;
          rise_c  = 1'b1;
        end
        S_HIGH: begin
          if (cnt_q == '0) begin
            step_d  = 1'b0;
            cnt_d   = div_q - half_c - DIV_W'(1);
            state_d = S_LOW;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        S_LOW: begin
          if (cnt_q == '0) begin
            rem_d = rem_q - STEP_W'(1);
            if (rem_q == STEP_W'(1)) begin
              done_d = 1'b1;
              // Zero-step segments are left for IDLE so each gets its own done pulse.
              if (full_q && (buf_steps_q != '0)) begin
                div_d   = (buf_div_q < DIV_W'(2)) ? DIV_W'(2) : buf_div_q;
                rem_d   = buf_steps_q;
                dir_d   = buf_dir_q;
                full_d  = 1'b0;
                state_d = S_SETUP;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              step_d  = 1'b1;
              cnt_d   = half_c - DIV_W'(1);
              state_d = S_HIGH;
              rise_c  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (accept_c) begin
        full_d      = 1'b1;
        buf_div_d   = cmd_divider;
        buf_steps_d = cmd_steps;
        buf_dir_d   = cmd_dir;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      full_q      <= 1'b0;
      buf_div_q   <= '0;
      buf_steps_q <= '0;
      buf_dir_q   <= 1'b0;
      div_q       <= DIV_W'(2);
      rem_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      buf_div_q   <= buf_div_d;
      buf_steps_q <= buf_steps_d;
      buf_dir_q   <= buf_dir_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      done_q      <= done_d;
    end
  end

`ifdef POSITION_TRACK_EN
  logic [POS_W-1:0] pos_q, pos_d;

  // Position moves on every step rising edge, in the direction already on the pin.
  always_comb begin
    pos_d = pos_q;
    if (rise_c) begin
      pos_d = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;
`else
  logic unused_pos_w;
  assign unused_pos_w = ^POS_W ^ rise_c;
`endif

endmodule

// File: tb/tb_motor_step_engine.sv
// Directed self-checking bench for motor_step_engine; position checks when POSITION_TRACK_EN is defined.
module tb_motor_step_engine;

  localparam int unsigned DIV_W  = 15;
  localparam int unsigned STEP_W = 14;
  localparam int unsigned POS_W  = 4;

  logic              CLK = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DIV_W-1:0]  cmd_divider;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic              abort;
  logic              dir;
  logic              step;
  logic              busy;
  logic              done;
`ifdef POSITION_TRACK_EN
  logic [POS_W-1:0]  position;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  motor_step_engine #(.DIV_W(DIV_W), .STEP_W(STEP_W), .POS_W(POS_W)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_divider(cmd_divider),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .dir        (dir),
    .step       (step),
    .busy       (busy),
    .done       (done)
`ifdef POSITION_TRACK_EN
    ,
    .position   (position)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input int d, input int s, input logic dr);
    cmd_valid   = 1'b1;
    cmd_divider = DIV_W'(d);
    cmd_steps   = STEP_W'(s);
    cmd_dir     = dr;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_divider = '0; cmd_steps = '0; cmd_dir = 1'b0;
    cycle(); cycle();
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL reset_step: got %b want 0", step); end
    tests_run++; if (dir !== 1'b0) begin tests_failed++; $display("FAIL reset_dir: got %b want 0", dir); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
`ifdef POSITION_TRACK_EN
    tests_run++; if (position !== 4'h0) begin tests_failed++; $display("FAIL reset_pos: got %h want 0", position); end
`endif
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    logic es, ed;
    apply_reset();
    offer(10, 3, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_acc: got %b want 1", busy); end
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL single_ready_acc: got %b want 0", cmd_ready); end
    cycle();
    tests_run++; if (dir !== 1'b1) begin tests_failed++; $display("FAIL single_dir_setup: got %b want 1", dir); end
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL single_step_setup: got %b want 0", step); end
    for (int k = 0; k < 32; k++) begin
      cycle();
      es = (k < 30) && ((k % 10) < 5);
      ed = (k == 30);
      tests_run++; if (step !== es) begin tests_failed++; $display("FAIL single_step k=%0d: got %b want %b", k, step, es); end
      tests_run++; if (done !== ed) begin tests_failed++; $display("FAIL single_done k=%0d: got %b want %b", k, done, ed); end
      if (k == 30) begin
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end: got %b want 0", busy); end
      end
    end
`ifdef POSITION_TRACK_EN
    tests_run++; if (position !== 4'h3) begin tests_failed++; $display("FAIL single_pos: got %h want 3", position); end
`endif
  endtask

  task automatic test_back_to_back();
    logic es, ed, edir, eb;
    apply_reset();
    offer(4, 2, 1'b0);
    cycle();
    offer(6, 1, 1'b1);
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_full: got %b want 0", cmd_ready); end
    cycle();
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_taken: got %b want 1", cmd_ready); end
    for (int k = 0; k < 17; k++) begin
      cycle();
      if (k == 0) cmd_valid = 1'b0;
      es   = (k < 8) ? ((k % 4) < 2) : ((k >= 9) && (k <= 11));
      ed   = (k == 8) || (k == 15);
      edir = (k >= 8);
      eb   = (k < 15);
      tests_run++; if (step !== es) begin tests_failed++; $display("FAIL b2b_step k=%0d: got %b want %b", k, step, es); end
      tests_run++; if (done !== ed) begin tests_failed++; $display("FAIL b2b_done k=%0d: got %b want %b", k, done, ed); end
      tests_run++; if (dir !== edir) begin tests_failed++; $display("FAIL b2b_dir k=%0d: got %b want %b", k, dir, edir); end
      tests_run++; if (busy !== eb) begin tests_failed++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, eb); end
    end
`ifdef POSITION_TRACK_EN
    tests_run++; if (position !== 4'hF) begin tests_failed++; $display("FAIL b2b_pos: got %h want f", position); end
`endif
  endtask

  task automatic test_min_divider();
    logic es, ed;
    for (int d = 0; d < 2; d++) begin
      apply_reset();
      offer(d, 2, 1'b0);
      cycle();
      cmd_valid = 1'b0;
      cycle();
      for (int k = 0; k < 6; k++) begin
        cycle();
        es = (k < 4) && ((k % 2) == 0);
        ed = (k == 4);
        tests_run++; if (step !== es) begin tests_failed++; $display("FAIL mindiv%0d_step k=%0d: got %b want %b", d, k, step, es); end
        tests_run++; if (done !== ed) begin tests_failed++; $display("FAIL mindiv%0d_done k=%0d: got %b want %b", d, k, done, ed); end
      end
    end
  endtask

  task automatic test_zero_steps();
    apply_reset();
    offer(5, 0, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL zero_busy_acc: got %b want 1", busy); end
    cycle();
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_done: got %b want 1", done); end
    tests_run++; if (dir !== 1'b1) begin tests_failed++; $display("FAIL zero_dir: got %b want 1", dir); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy: got %b want 0", busy); end
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL zero_step: got %b want 0", step); end
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL zero_done_after k=%0d: got %b want 0", k, done); end
      tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL zero_step_after k=%0d: got %b want 0", k, step); end
    end
`ifdef POSITION_TRACK_EN
    tests_run++; if (position !== 4'h0) begin tests_failed++; $display("FAIL zero_pos: got %h want 0", position); end
`endif
  endtask

  task automatic test_abort();
    logic es;
    apply_reset();
    offer(8, 5, 1'b1);
    cycle();
    offer(8, 3, 1'b0);
    cycle();
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k == 0) cmd_valid = 1'b0;
      es = ((k % 8) < 4);
      tests_run++; if (step !== es) begin tests_failed++; $display("FAIL abort_step k=%0d: got %b want %b", k, step, es); end
    end
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_buf_full: got %b want 0", cmd_ready); end
    abort = 1'b1;
    cycle();
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL abort_step_low: got %b want 0", step); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b want 0", busy); end
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_done: got %b want 0", done); end
    offer(8, 3, 1'b0);
    cycle();
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_accept_dropped: got ready %b want 1", cmd_ready); end
    abort = 1'b0;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_busy k=%0d: got %b want 0", k, busy); end
      tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_step k=%0d: got %b want 0", k, step); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL abort_idle_done k=%0d: got %b want 0", k, done); end
    end
    tests_run++; if (dir !== 1'b1) begin tests_failed++; $display("FAIL abort_dir: got %b want 1", dir); end
`ifdef POSITION_TRACK_EN
    tests_run++; if (position !== 4'h2) begin tests_failed++; $display("FAIL abort_pos: got %h want 2", position); end
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    offer(10, 3, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();
    tests_run++; if (step !== 1'b1) begin tests_failed++; $display("FAIL areset_step_before: got %b want 1", step); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (step !== 1'b0) begin tests_failed++; $display("FAIL areset_step: got %b want 0", step); end
    tests_run++; if (dir !== 1'b0) begin tests_failed++; $display("FAIL areset_dir: got %b want 0", dir); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL areset_busy: got %b want 0", busy); end
    cycle();
    reset = 1'b0;
    cycle();
  endtask

`ifdef POSITION_TRACK_EN
  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while ((done !== 1'b1) && (n < limit)) begin
      cycle();
      n++;
    end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL %s_timeout: got done %b want 1 within %0d cycles", tag, done, limit); end
  endtask

  task automatic test_position_wrap();
    apply_reset();
    offer(2, 7, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    wait_done(40, "wrap_a");
    tests_run++; if (position !== 4'h7) begin tests_failed++; $display("FAIL wrap_pos7: got %h want 7", position); end
    offer(2, 1, 1'b1);
    cycle();
    cmd_valid = 1'b0;
    wait_done(20, "wrap_b");
    tests_run++; if (position !== 4'h8) begin tests_failed++; $display("FAIL wrap_pos_neg8: got %h want 8", position); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_min_divider();
    test_zero_steps();
    test_abort();
    test_async_reset();
`ifdef POSITION_TRACK_EN
    test_position_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
